// File: rtl/mult_pkg.sv
// Shared types for the add-shift multiplier datapath: operand width,
// the byte type, the decoded command and the register-file payload.
package mult_pkg;

  localparam int unsigned WIDTH = 8;

  typedef logic [WIDTH-1:0] byte_t;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_CLRLD = 3'd1,
    CMD_CLRA  = 3'd2,
    CMD_SUB   = 3'd3,
    CMD_ADD   = 3'd4,
    CMD_SHIFT = 3'd5
  } cmd_t;

  typedef struct packed {
    logic  x;
    byte_t a;
    byte_t b;
  } regs_t;

  // Collapse the one-hot-ish controller strobes into a single command.
  // Order of the tests is the execution priority.
  function automatic cmd_t encode_cmd(input logic clr_ld,
                                      input logic clr_a,
                                      input logic sub,
                                      input logic add,
                                      input logic shift);
    cmd_t cmd;
    cmd = CMD_NONE;
    if (clr_ld) begin
      cmd = CMD_CLRLD;
    end else if (clr_a) begin
      cmd = CMD_CLRA;
    end else if (sub) begin
      cmd = CMD_SUB;
    end else if (add) begin
      cmd = CMD_ADD;
    end else if (shift) begin
      cmd = CMD_SHIFT;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/mult_register_unit_add_sub9.sv
// (WIDTH+1)-bit two's-complement ripple adder/subtractor built from
// full-adder cells; both operands are sign-extended by one bit.

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module add_sub9
  import mult_pkg::*;
(
  input  byte_t              a,
  input  byte_t              s,
  input  logic               sub,
  output logic [WIDTH:0]     sum
);

  logic [WIDTH:0] op_a;
  logic [WIDTH:0] op_s;
  logic [WIDTH:0] op_b;
  logic [WIDTH:0] carry;

  assign op_a = {a[WIDTH-1], a};
  assign op_s = {s[WIDTH-1], s};
  // Subtract as op_a + ~op_s + 1: invert the operand, inject 1 as carry-in.
  assign op_b     = op_s ^ {(WIDTH + 1){sub}};
  assign carry[0] = sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_fa (
      .a    (op_a[i]),
      .b    (op_b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  // Sign bit: the carry out of this position is discarded, so only the sum is formed.
  assign sum[WIDTH] = op_a[WIDTH] ^ op_b[WIDTH] ^ carry[WIDTH];

endmodule

// File: rtl/mult_register_unit.sv
// Register stage under the add-shift multiplier controller: holds X, A and B
// and executes one controller command per clock.
module mult_register_unit
  import mult_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic [WIDTH-1:0]  S,
  input  logic              Clr_Ld,
  input  logic              ClrA,
  input  logic              Add,
  input  logic              Sub,
  input  logic              Shift,
  output logic [WIDTH-1:0]  Aval,
  output logic [WIDTH-1:0]  Bval,
  output logic              X,
  output logic              M
);

  cmd_t            cmd;
  logic [WIDTH:0]  sum;
  regs_t           regs_d;
  regs_t           regs_q;

  always_comb begin
    cmd = encode_cmd(Clr_Ld, ClrA, Sub, Add, Shift);
  end

  add_sub9 u_add_sub9 (
    .a   (regs_q.a),
    .s   (S),
    .sub (cmd == CMD_SUB),
    .sum (sum)
  );

  // Next-state selection; anything not commanded holds.
  always_comb begin
    regs_d = regs_q;
    unique case (cmd)
      CMD_CLRLD: begin
        regs_d.x = 1'b0;
        regs_d.a = '0;
        regs_d.b = S;
      end
      CMD_CLRA: begin
        regs_d.x = 1'b0;
        regs_d.a = '0;
      end
      CMD_SUB, CMD_ADD: begin
        regs_d.x = sum[WIDTH];
        regs_d.a = sum[WIDTH-1:0];
      end
      CMD_SHIFT: begin
        regs_d.a = {regs_q.x, regs_q.a[WIDTH-1:1]};
        regs_d.b = {regs_q.a[0], regs_q.b[WIDTH-1:1]};
      end
      default: begin
        regs_d = regs_q;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign Aval = regs_q.a;
  assign Bval = regs_q.b;
  assign X    = regs_q.x;
  // Multiplier LSB back to the controller, straight from the register.
  assign M    = regs_q.b[0];

endmodule

// File: tb/tb_mult_register_unit.sv
// Scoreboard bench for mult_register_unit: a behavioural model pushes the
// expected X/A/B per command, compared after each commanding edge.
module tb_mult_register_unit;

  logic       Clk;
  logic       Reset;
  logic [7:0] S;
  logic       Clr_Ld, ClrA, Add, Sub, Shift;
  logic [7:0] Aval, Bval;
  logic       X, M;

  typedef struct packed {
    logic       x;
    logic [7:0] a;
    logic [7:0] b;
  } exp_t;

  exp_t sb_q[$];
  exp_t m;
  int   checks;
  int   errors;

  mult_register_unit dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .S      (S),
    .Clr_Ld (Clr_Ld),
    .ClrA   (ClrA),
    .Add    (Add),
    .Sub    (Sub),
    .Shift  (Shift),
    .Aval   (Aval),
    .Bval   (Bval),
    .X      (X),
    .M      (M)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Drive one command for one edge, update the model, queue its result.
  task automatic apply(input logic cl, input logic ca, input logic su,
                       input logic ad, input logic sh, input logic [7:0] s);
    int sum;
    Clr_Ld = cl; ClrA = ca; Sub = su; Add = ad; Shift = sh; S = s;
    if (cl) begin
      m.x = 1'b0; m.a = 8'h00; m.b = s;
    end else if (ca) begin
      m.x = 1'b0; m.a = 8'h00;
    end else if (su) begin
      sum = int'($signed(m.a)) - int'($signed(s));
      {m.x, m.a} = 9'(sum);
    end else if (ad) begin
      sum = int'($signed(m.a)) + int'($signed(s));
      {m.x, m.a} = 9'(sum);
    end else if (sh) begin
      m.b = {m.a[0], m.b[7:1]};
      m.a = {m.x, m.a[7:1]};
    end
    sb_q.push_back(m);
    @(posedge Clk);
    #1;
    Clr_Ld = 1'b0; ClrA = 1'b0; Sub = 1'b0; Add = 1'b0; Shift = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    S = 8'hA5; Clr_Ld = 1'b0; ClrA = 1'b0; Add = 1'b0; Sub = 1'b0; Shift = 1'b0;
    m = '0;
    #1;
    checks++;
    if ({X, Aval, Bval, M} !== {1'b0, 8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset: X=%b A=%h B=%h M=%b, want 0 00 00 0", X, Aval, Bval, M);
    end
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_load_hold;
    exp_t e;
    apply(1, 0, 0, 0, 0, 8'h07);
    e = sb_q.pop_front();
    checks++;
    if ({X, Aval, Bval, M} !== {e.x, e.a, e.b, e.b[0]} ||
        {X, Aval, Bval, M} !== {1'b0, 8'h00, 8'h07, 1'b1}) begin
      errors++;
      $display("FAIL load: X=%b A=%h B=%h M=%b, want 0 00 07 1", X, Aval, Bval, M);
    end
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 0, 8'h55);
      e = sb_q.pop_front();
      checks++;
      if ({X, Aval, Bval, M} !== {e.x, e.a, e.b, e.b[0]} || Bval !== 8'h07) begin
        errors++;
        $display("FAIL hold[%0d]: X=%b A=%h B=%h, want %b %h %h", i, X, Aval, Bval, e.x, e.a, e.b);
      end
    end
  endtask

  task automatic test_add_shift;
    exp_t e;
    apply(0, 1, 0, 0, 0, 8'h00);
    void'(sb_q.pop_front());
    apply(0, 0, 0, 1, 0, 8'hC5);
    e = sb_q.pop_front();
    checks++;
    if ({X, Aval, Bval} !== {e.x, e.a, e.b} || {X, Aval} !== {1'b1, 8'hC5}) begin
      errors++;
      $display("FAIL add_c5: X=%b A=%h B=%h, want 1 c5 %h", X, Aval, Bval, e.b);
    end
    apply(0, 0, 0, 0, 1, 8'h00);
    e = sb_q.pop_front();
    checks++;
    if ({X, Aval, Bval, M} !== {e.x, e.a, e.b, e.b[0]} ||
        {X, Aval, Bval, M} !== {1'b1, 8'hE2, 8'h83, 1'b1}) begin
      errors++;
      $display("FAIL shift: X=%b A=%h B=%h M=%b, want 1 e2 83 1", X, Aval, Bval, M);
    end
  endtask

  task automatic test_sub;
    exp_t e;
    apply(0, 1, 0, 0, 0, 8'h00);
    void'(sb_q.pop_front());
    apply(0, 0, 1, 0, 0, 8'h80);
    e = sb_q.pop_front();
    checks++;
    if ({X, Aval} !== {e.x, e.a} || {X, Aval} !== {1'b0, 8'h80}) begin
      errors++;
      $display("FAIL sub_80: X=%b A=%h, want 0 80", X, Aval);
    end
    apply(0, 1, 0, 0, 0, 8'h00);
    void'(sb_q.pop_front());
    apply(0, 0, 1, 1, 0, 8'h03);
    e = sb_q.pop_front();
    checks++;
    if ({X, Aval, Bval} !== {e.x, e.a, e.b} || {X, Aval} !== {1'b1, 8'hFD}) begin
      errors++;
      $display("FAIL add_sub_both: X=%b A=%h, want 1 fd", X, Aval);
    end
  endtask

  task automatic test_priority;
    exp_t e;
    apply(0, 0, 0, 1, 0, 8'h11);
    void'(sb_q.pop_front());
    apply(1, 0, 0, 0, 1, 8'h2B);
    e = sb_q.pop_front();
    checks++;
    if ({X, Aval, Bval} !== {e.x, e.a, e.b} || {X, Aval, Bval} !== {1'b0, 8'h00, 8'h2B}) begin
      errors++;
      $display("FAIL clrld_shift: X=%b A=%h B=%h, want 0 00 2b", X, Aval, Bval);
    end
    apply(0, 0, 0, 1, 0, 8'h66);
    void'(sb_q.pop_front());
    apply(0, 1, 0, 1, 0, 8'h10);
    e = sb_q.pop_front();
    checks++;
    if ({X, Aval, Bval} !== {e.x, e.a, e.b} || {X, Aval, Bval} !== {1'b0, 8'h00, 8'h2B}) begin
      errors++;
      $display("FAIL clra_add: X=%b A=%h B=%h, want 0 00 2b", X, Aval, Bval);
    end
  endtask

  // Controller-style multiply, decisions taken from the model's B[0].
  task automatic test_multiply(input logic [7:0] mplier, input logic [7:0] mcand);
    exp_t e;
    apply(1, 0, 0, 0, 0, mplier);
    void'(sb_q.pop_front());
    apply(0, 1, 0, 0, 0, mcand);
    void'(sb_q.pop_front());
    for (int i = 0; i < 8; i++) begin
      if (m.b[0]) begin
        apply(0, 0, (i == 7), (i != 7), 0, mcand);
        e = sb_q.pop_front();
        checks++;
        if ({X, Aval, Bval, M} !== {e.x, e.a, e.b, e.b[0]}) begin
          errors++;
          $display("FAIL mul_%h_%h addsub[%0d]: X=%b A=%h B=%h, want %b %h %h",
                   mplier, mcand, i, X, Aval, Bval, e.x, e.a, e.b);
        end
      end
      apply(0, 0, 0, 0, 1, mcand);
      e = sb_q.pop_front();
      checks++;
      if ({X, Aval, Bval, M} !== {e.x, e.a, e.b, e.b[0]}) begin
        errors++;
        $display("FAIL mul_%h_%h shift[%0d]: X=%b A=%h B=%h, want %b %h %h",
                 mplier, mcand, i, X, Aval, Bval, e.x, e.a, e.b);
      end
    end
    checks++;
    if ({X, Aval, Bval} !== {1'b1, 8'hFF, 8'hEB}) begin
      errors++;
      $display("FAIL mul_%h_%h product: X=%b A=%h B=%h, want 1 ff eb", mplier, mcand, X, Aval, Bval);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic [4:0] f;
    for (int i = 0; i < 60; i++) begin
      f = 5'($urandom);
      apply(f[4] & f[3] & f[2], f[1] & f[0] & f[4], f[3], f[2], f[1], 8'($urandom));
      e = sb_q.pop_front();
      checks++;
      if ({X, Aval, Bval, M} !== {e.x, e.a, e.b, e.b[0]}) begin
        errors++;
        $display("FAIL b2b[%0d]: X=%b A=%h B=%h M=%b, want %b %h %h",
                 i, X, Aval, Bval, M, e.x, e.a, e.b);
      end
    end
  endtask

  task automatic test_reset_mid_shift;
    exp_t e;
    apply(1, 0, 0, 0, 0, 8'h3C);
    void'(sb_q.pop_front());
    apply(0, 0, 0, 1, 0, 8'h80);
    void'(sb_q.pop_front());
    apply(0, 0, 0, 1, 0, 8'hDA);
    e = sb_q.pop_front();
    checks++;
    if ({X, Aval, Bval} !== {e.x, e.a, e.b} || {X, Aval, Bval} !== {1'b1, 8'h5A, 8'h3C}) begin
      errors++;
      $display("FAIL preload: X=%b A=%h B=%h, want 1 5a 3c", X, Aval, Bval);
    end
    Shift = 1'b1;
    #3;
    Reset = 1'b1;
    #1;
    checks++;
    if ({X, Aval, Bval, M} !== {1'b0, 8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_shift: X=%b A=%h B=%h M=%b, want 0 00 00 0", X, Aval, Bval, M);
    end
    Shift = 1'b0;
    m = '0;
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    checks++;
    if ({X, Aval, Bval, M} !== {1'b0, 8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL post_reset_hold: X=%b A=%h B=%h M=%b, want 0 00 00 0", X, Aval, Bval, M);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load_hold();
    test_add_shift();
    test_sub();
    test_priority();
    test_multiply(8'h07, 8'hFD);
    test_multiply(8'hFD, 8'h07);
    test_back_to_back();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
